// File: rtl/srambank_initiator.sv
// Request-side controller for one synchronous SRAM bank. It turns a valid/ready request stream into bank strobes and
// returns read data in order through a credit-checked response FIFO. SRAMBANK_INIT_CLEAR_EN adds a zero-fill sweep after reset.
module srambank_initiator #(
  parameter int AW        = 9,
  parameter int DW        = 72,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_done,
  output logic [AW-1:0] ADDRESS,
  output logic [DW-1:0] wd,
  output logic          banksel,
  output logic          read,
  output logic          write,
  input  logic [DW-1:0] dataout
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  logic          init_done_q;
  logic          run;
  logic          sweep;
  logic [AW-1:0] sweep_addr;

`ifdef SRAMBANK_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  state_e        state_q;
  logic          sweep_q;
  logic [AW-1:0] swp_cnt_q;

  // The sweep starts one edge after reset so every strobe is low while rst_n is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_done_q <= 1'b0;
      sweep_q     <= 1'b0;
      swp_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (!sweep_q) sweep_q <= 1'b1;
          else begin
            swp_cnt_q <= swp_cnt_q + 1'b1;
            if (&swp_cnt_q) begin
              sweep_q     <= 1'b0;
              state_q     <= ST_RUN;
              init_done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign run        = init_done_q & (state_q == ST_RUN);
  assign sweep      = sweep_q;
  assign sweep_addr = swp_cnt_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done_q <= 1'b0;
    else        init_done_q <= 1'b1;
  end

  assign run        = init_done_q;
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
`endif

  assign init_done = init_done_q;

  logic [DW-1:0] mem_q [RSP_DEPTH];
  logic [DW-1:0] mem_d [RSP_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic [CW-1:0] occ;
  logic          acc, push, pop;

  // Credit covers the read still in flight in the bank as well as the queued entries.
  assign occ       = cnt_q + CW'(rd_pend_q);
  assign req_ready = run & (occ < DEPTH_C);
  assign acc       = req_valid & req_ready;

  always_comb begin
    banksel = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    ADDRESS = '0;
    wd      = '0;
    if (sweep) begin
      banksel = 1'b1;
      write   = 1'b1;
      ADDRESS = sweep_addr;
    end else if (run) begin
      banksel = acc;
      write   = acc & req_write;
      read    = acc & ~req_write;
      ADDRESS = req_addr;
      wd      = req_wdata;
    end
  end

  assign push      = rd_pend_q;
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_rdata = mem_q[rptr_q];

  always_comb begin
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    rd_pend_d = run & acc & ~req_write;
    if (push) begin
      mem_d[wptr_q] = dataout;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end
endmodule

// File: tb/tb_srambank_initiator.sv
// Bench for srambank_initiator: a behavioural bank and a queue-based reference model, checked on every cycle, plus directed literal checks.
module tb_srambank_initiator;
  localparam int AW = 9;
  localparam int DW = 72;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, init_done, banksel, read, write;
  logic [DW-1:0] rsp_rdata, wd;
  logic [DW-1:0] dataout = '0;
  logic [AW-1:0] ADDRESS;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  srambank_initiator #(.AW(AW), .DW(DW), .RSP_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .ADDRESS(ADDRESS), .wd(wd), .banksel(banksel),
    .read(read), .write(write), .dataout(dataout)
  );

  // Bank: synchronous write, one-cycle registered read.
  logic [DW-1:0] bank_mem [2**AW];
  initial for (int i = 0; i < 2**AW; i++) bank_mem[i] = '0;
  always @(posedge clk) begin
    if (banksel && write) bank_mem[ADDRESS] <= wd;
    if (banksel && read)  dataout <= bank_mem[ADDRESS];
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: reads become queue entries that turn visible one edge after the edge that accepted them.
  typedef struct { logic [DW-1:0] d; int acc; } ent_t;
  ent_t          q[$];
  logic [DW-1:0] ref_mem [2**AW];
  bit            ref_init = 1'b0;
  int            ec = 0;
  initial for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;

  function automatic bit exp_ready();
    return rst_n && ref_init && (q.size() < D);
  endfunction
  function automatic bit exp_valid();
    return rst_n && (q.size() > 0) && (ec >= q[0].acc + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      ref_init = 1'b0;
    end else begin
      bit pop, acc;
      ent_t e;
      pop = exp_valid() && rsp_ready;
      acc = req_valid && exp_ready();
      ec++;
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (req_write) ref_mem[req_addr] = req_wdata;
        else begin
          e.d = ref_mem[req_addr];
          e.acc = ec;
          q.push_back(e);
        end
      end
      ref_init = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", DW'(req_ready), '0);
      chk("rst_rsp_valid", DW'(rsp_valid), '0);
      chk("rst_rsp_rdata", rsp_rdata, '0);
      chk("rst_init_done", DW'(init_done), '0);
      chk("rst_strobes", DW'({banksel, read, write}), '0);
      chk("rst_address", DW'(ADDRESS), '0);
      chk("rst_wd", wd, '0);
    end else begin
      bit bs;
      bs = req_valid && exp_ready();
      chk("req_ready", DW'(req_ready), DW'(exp_ready()));
      chk("init_done", DW'(init_done), DW'(ref_init));
      chk("rsp_valid", DW'(rsp_valid), DW'(exp_valid()));
      if (exp_valid()) chk("rsp_rdata", rsp_rdata, q[0].d);
      chk("banksel", DW'(banksel), DW'(bs));
      chk("write", DW'(write), DW'(bs && req_write));
      chk("read", DW'(read), DW'(bs && !req_write));
      if (bs) begin
        chk("address", DW'(ADDRESS), DW'(req_addr));
        chk("wd", wd, req_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [DW-1:0] pat;
    pat = {9{8'hAB}};

    repeat (3) @(negedge clk);
    chk("lit_rst_ready", DW'(req_ready), '0);
    chk("lit_rst_valid", DW'(rsp_valid), '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_init_before_edge", DW'(init_done), '0);
    @(negedge clk);
    chk("lit_init_done", DW'(init_done), 1);
    chk("lit_req_ready", DW'(req_ready), 1);

    // Write then read the same address on consecutive cycles.
    step();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h1F; req_wdata = pat;
    step();
    req_write = 1'b0;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("lit_rd_lat1", DW'(rsp_valid), '0);
    @(negedge clk);
    chk("lit_rd_lat2_valid", DW'(rsp_valid), 1);
    chk("lit_rd_data", rsp_rdata, pat);
    step();
    rsp_ready = 1'b1;
    repeat (3) step();

    // Back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(9'h40 + i);
      req_wdata = {8'($urandom), $urandom, $urandom};
      step();
    end
    n = 0;
    req_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = AW'(9'h40 + i);
      @(negedge clk);
      chk("lit_b2b_ready", DW'(req_ready), 1);
      if (rsp_valid) n++;
      step();
    end
    req_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) n++;
      step();
    end
    chk("lit_b2b_count", DW'(n), 8);

    // Stalled consumer: exactly four credits.
    rsp_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'($urandom_range(0, 15));
      @(negedge clk);
      if (req_ready) n++;
      step();
    end
    req_valid = 1'b0;
    chk("lit_stall_accepts", DW'(n), 4);
    repeat (3) step();
    rsp_ready = 1'b1;
    repeat (8) step();

    // Reset with two queued responses and one read in flight.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h1F;
    step(); step(); step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_midrst_valid", DW'(rsp_valid), '0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("lit_postrst_valid", DW'(rsp_valid), '0);
    end
    step();

    // Randomized traffic; narrow address range to exercise write/read hazards.
    for (int i = 0; i < 3000; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = $urandom_range(0, 1) != 0;
      req_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      req_wdata = {8'($urandom), $urandom, $urandom};
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("lit_final_drained", DW'(rsp_valid), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
